// File: rtl/memory_arbiter.sv
// Shares one single-ported memory between the instruction-fetch port and the
// data port. Round-robin grant on conflict, variable-latency memory
// acknowledge, registered instruction/load results.
// Optional access timeout is compiled in with `define MEM_TIMEOUT_EN.
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_address,
  output logic                  inst_valid,
  output logic [31:0]           inst_data,
  input  logic                  data_req,
  input  logic                  data_write_enable,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [31:0]           data_write_data,
  input  logic [2:0]            data_format,
  output logic                  data_valid,
  output logic [31:0]           data_read_data,
  output logic                  mem_req,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic [2:0]            mem_format,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_read_data,
  output logic                  busy,
  output logic                  bus_error
);

  typedef enum logic [1:0] {StIdle, StInstAccess, StDataAccess, StRespond} state_e;

  localparam logic GrantInst = 1'b0;
  localparam logic GrantData = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            fmt_q, fmt_d;
  logic                  we_q, we_d;
  logic [31:0]           inst_data_q, inst_data_d;
  logic [31:0]           data_rdata_q, data_rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            limit_hit;

  // cnt_q counts completed ack-less access cycles; the current cycle is the last allowed one.
  assign limit_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state: grant arbitration, access sequencing and result capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fmt_d        = fmt_q;
    we_d         = we_q;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Data wins unless inst also requests and data held the last grant.
        if (data_req && (!inst_req || (last_grant_q == GrantInst))) begin
          state_d      = StDataAccess;
          last_grant_d = GrantData;
          addr_d       = data_address;
          wdata_d      = data_write_data;
          fmt_d        = data_format;
          we_d         = data_write_enable;
`ifdef MEM_TIMEOUT_EN
          cnt_d        = '0;
          err_d        = 1'b0;
`endif
        end else if (inst_req) begin
          state_d      = StInstAccess;
          last_grant_d = GrantInst;
          addr_d       = inst_address;
          wdata_d      = '0;
          fmt_d        = 3'b010;
          we_d         = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d        = '0;
          err_d        = 1'b0;
`endif
        end
      end
      StInstAccess, StDataAccess: begin
        if (mem_ack) begin
          if (state_q == StInstAccess) begin
            inst_data_d = mem_read_data;
          end else if (!we_q) begin
            data_rdata_d = mem_read_data;
          end
          state_d = StRespond;
        end
`ifdef MEM_TIMEOUT_EN
        else if (limit_hit) begin
          // Aborted reads leave a defined zero rather than stale data.
          if (state_q == StInstAccess) begin
            inst_data_d = '0;
          end else if (!we_q) begin
            data_rdata_d = '0;
          end
          err_d   = 1'b1;
          state_d = StRespond;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StRespond: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= GrantInst;
      addr_q       <= '0;
      wdata_q      <= '0;
      fmt_q        <= '0;
      we_q         <= 1'b0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fmt_q        <= fmt_d;
      we_q         <= we_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Timeout counter and abort flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_error = (state_q == StRespond) && err_q;
`else
  assign bus_error = 1'b0;
`endif

  // Memory side is driven purely from the registers latched at grant.
  assign mem_req          = (state_q == StInstAccess) || (state_q == StDataAccess);
  assign mem_write_enable = (state_q == StDataAccess) && we_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_format       = fmt_q;

  assign inst_valid     = (state_q == StRespond) && (last_grant_q == GrantInst);
  assign data_valid     = (state_q == StRespond) && (last_grant_q == GrantData);
  assign inst_data      = inst_data_q;
  assign data_read_data = data_rdata_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: scoreboard of expected completions
// plus per-scenario timing checks. Timeout scenario needs MEM_TIMEOUT_EN.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_address = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        data_req = 1'b0;
  logic        data_write_enable = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_write_data = '0;
  logic [2:0]  data_format = '0;
  logic        data_valid;
  logic [31:0] data_read_data;
  logic        mem_req;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_format;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_read_data = '0;
  logic        busy;
  logic        bus_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Memory responder configuration.
  int   wait_cfg = 0;
  logic never_ack = 1'b0;
  logic force_ack = 1'b0;
  int   ws_cnt = 0;

  typedef struct packed {
    logic        is_data;
    logic [31:0] inst_d;
    logic [31:0] data_d;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_dread = '0;

  memory_arbiter #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .inst_req         (inst_req),
    .inst_address     (inst_address),
    .inst_valid       (inst_valid),
    .inst_data        (inst_data),
    .data_req         (data_req),
    .data_write_enable(data_write_enable),
    .data_address     (data_address),
    .data_write_data  (data_write_data),
    .data_format      (data_format),
    .data_valid       (data_valid),
    .data_read_data   (data_read_data),
    .mem_req          (mem_req),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_format       (mem_format),
    .mem_ack          (mem_ack),
    .mem_read_data    (mem_read_data),
    .busy             (busy),
    .bus_error        (bus_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] model_mem(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0062_8293;
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: acks after wait_cfg wait states, drives read data from its contents.
  always @(negedge clock) begin
    mem_read_data = model_mem(mem_address);
    if (force_ack) begin
      mem_ack = 1'b1;
    end else if (mem_req && !never_ack) begin
      if (ws_cnt >= wait_cfg) begin
        mem_ack = 1'b1;
        ws_cnt  = 0;
      end else begin
        mem_ack = 1'b0;
        ws_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      ws_cnt  = 0;
    end
  end

  // Scoreboard: every valid pulse must match the oldest expected completion.
  always @(negedge clock) begin
    if (inst_valid || data_valid) begin
      checks++;
      if (inst_valid && data_valid) begin
        failures++;
        $display("FAIL both_valid inst_valid=1 data_valid=1 required=one-hot");
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid inst_valid=%0b data_valid=%0b required=none",
                 inst_valid, data_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({data_valid, inst_data, data_read_data, bus_error} !== e) begin
          failures++;
          $display("FAIL sb_completion got port=%0b inst=%h data=%h err=%0b exp port=%0b inst=%h data=%h err=%0b",
                   data_valid, inst_data, data_read_data, bus_error,
                   e.is_data, e.inst_d, e.data_d, e.err);
        end
      end
    end
  end

  task automatic apply_reset();
    reset    = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    never_ack = 1'b0;
    force_ack = 1'b0;
    wait_cfg = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_inst  = '0;
    exp_dread = '0;
    sb.delete();
  endtask

  // Drive one request and wait (bounded) for its valid; the expectation is queued first.
  task automatic do_access(input logic is_data, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input int ws, input logic err);
    exp_t e;
    logic seen;
    wait_cfg = ws;
    if (!is_data) exp_inst = err ? 32'h0 : model_mem(addr);
    else if (!we) exp_dread = err ? 32'h0 : model_mem(addr);
    e = '{is_data, exp_inst, exp_dread, err};
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (is_data) begin
      data_req = 1'b1; data_write_enable = we; data_address = addr;
      data_write_data = wd; data_format = 3'b010;
    end else begin
      inst_req = 1'b1; inst_address = addr;
    end
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (is_data ? data_valid : inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL access_timeout addr=%h valid=0 required=1 within 60 cycles", addr);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, mem_req, mem_write_enable, mem_address, mem_write_data, mem_format,
         inst_valid, data_valid, inst_data, data_read_data, bus_error} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%0b mem_req=%0b addr=%h inst=%h data=%h required=all zero",
               busy, mem_req, mem_address, inst_data, data_read_data);
    end
    apply_reset();
    // Interrupt a load that the memory never acknowledges.
    never_ack = 1'b1;
    @(posedge clock);
    #1 data_req = 1'b1; data_write_enable = 1'b0; data_address = 32'h500;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_access mem_req=%0b required=1", mem_req);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_async_drop mem_req=%0b busy=%0b required=0 0", mem_req, busy);
    end
    data_req  = 1'b0;
    never_ack = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({data_valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL reset_no_valid data_valid=%0b busy=%0b required=0 0", data_valid, busy);
      end
    end
  endtask

  task automatic test_fetch();
    exp_t e;
    wait_cfg = 0;
    exp_inst = 32'h0062_8293;
    e = '{1'b0, exp_inst, exp_dread, 1'b0};
    sb.push_back(e);
    @(posedge clock);
    #1 inst_req = 1'b1; inst_address = 32'h10;
    @(posedge clock);  // cycle N: grant
    @(negedge clock);  // N+1
    checks++;
    if ({mem_req, mem_write_enable, mem_address, mem_format} !== {1'b1, 1'b0, 32'h10, 3'b010}) begin
      failures++;
      $display("FAIL fetch_mem_drive req=%0b we=%0b addr=%h fmt=%b required=1 0 00000010 010",
               mem_req, mem_write_enable, mem_address, mem_format);
    end
    @(posedge clock);
    @(negedge clock);  // N+2
    checks++;
    if ({inst_valid, inst_data} !== {1'b1, 32'h0062_8293}) begin
      failures++;
      $display("FAIL fetch_latency inst_valid=%0b inst_data=%h required=1 00628293",
               inst_valid, inst_data);
    end
    inst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({inst_valid, inst_data} !== {1'b0, 32'h0062_8293}) begin
        failures++;
        $display("FAIL fetch_hold inst_valid=%0b inst_data=%h required=0 00628293",
                 inst_valid, inst_data);
      end
    end
  endtask

  task automatic test_store();
    exp_t e;
    do_access(1'b1, 1'b0, 32'h2000, 32'h0, 0, 1'b0);  // gives data_read_data a nonzero value
    wait_cfg = 3;
    e = '{1'b1, exp_inst, exp_dread, 1'b0};
    sb.push_back(e);
    @(posedge clock);
    #1 data_req = 1'b1; data_write_enable = 1'b1; data_address = 32'h2004;
    data_write_data = 32'hDEAD_BEEF; data_format = 3'b010;
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({mem_req, mem_write_enable, mem_address, mem_write_data, mem_format, data_valid} !==
          {1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 1'b0}) begin
        failures++;
        $display("FAIL store_drive cyc%0d req=%0b we=%0b addr=%h wd=%h fmt=%b valid=%0b required=1 1 00002004 deadbeef 010 0",
                 i, mem_req, mem_write_enable, mem_address, mem_write_data, mem_format, data_valid);
      end
    end
    @(negedge clock);
    checks++;
    if ({data_valid, mem_req} !== 2'b10) begin
      failures++;
      $display("FAIL store_valid data_valid=%0b mem_req=%0b required=1 0", data_valid, mem_req);
    end
    data_req = 1'b0;
    data_write_enable = 1'b0;
  endtask

  task automatic test_payload_hold();
    exp_t e;
    wait_cfg = 3;
    exp_dread = model_mem(32'h100);
    e = '{1'b1, exp_inst, exp_dread, 1'b0};
    sb.push_back(e);
    @(posedge clock);
    #1 data_req = 1'b1; data_write_enable = 1'b0; data_address = 32'h100;
    @(posedge clock);
    #1 data_address = 32'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({mem_req, mem_address} !== {1'b1, 32'h100}) begin
        failures++;
        $display("FAIL payload_hold cyc%0d mem_req=%0b mem_address=%h required=1 00000100",
                 i, mem_req, mem_address);
      end
    end
    @(negedge clock);
    checks++;
    if (data_valid !== 1'b1) begin
      failures++;
      $display("FAIL payload_valid data_valid=%0b required=1", data_valid);
    end
    data_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   vcyc[$];
    int   n;
    apply_reset();
    wait_cfg = 0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_dread = model_mem(32'h80);
      else exp_inst = model_mem(32'h40);
      e = '{(k % 2 == 0), exp_inst, exp_dread, 1'b0};
      sb.push_back(e);
    end
    @(posedge clock);
    #1 inst_req = 1'b1; inst_address = 32'h40;
    data_req = 1'b1; data_write_enable = 1'b0; data_address = 32'h80;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clock);
      if (inst_valid || data_valid) begin
        vcyc.push_back(cyc);
        n++;
      end
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL b2b_count valids=%0d required=4", n);
    end
    for (int k = 1; k < vcyc.size(); k++) begin
      checks++;
      if (vcyc[k] - vcyc[k-1] != 3) begin
        failures++;
        $display("FAIL b2b_spacing idx=%0d gap=%0d required=3", k, vcyc[k] - vcyc[k-1]);
      end
    end
  endtask

  task automatic test_ack_ignored();
    repeat (2) @(posedge clock);
    #1 force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({busy, mem_req, inst_valid, data_valid} !== 4'b0000) begin
        failures++;
        $display("FAIL idle_ack busy=%0b mem_req=%0b iv=%0b dv=%0b required=0 0 0 0",
                 busy, mem_req, inst_valid, data_valid);
      end
    end
    @(posedge clock);
    #1 force_ack = 1'b0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   nreq;
    logic seen;
    apply_reset();
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b0);
    never_ack = 1'b1;
    exp_dread = 32'h0;
    e = '{1'b1, exp_inst, exp_dread, 1'b1};
    sb.push_back(e);
    @(posedge clock);
    #1 data_req = 1'b1; data_write_enable = 1'b0; data_address = 32'h300;
    @(posedge clock);
    nreq = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (mem_req) nreq++;
      if (data_valid) begin
        seen = 1'b1;
        break;
      end
    end
    data_req  = 1'b0;
    never_ack = 1'b0;
    checks++;
    if (!seen || nreq != 4) begin
      failures++;
      $display("FAIL timeout_abort seen=%0b access_cycles=%0d required=1 4", seen, nreq);
    end
    do_access(1'b1, 1'b0, 32'h304, 32'h0, 3, 1'b0);  // ack on the limit cycle wins
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_payload_hold();
    test_ack_ignored();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
